// File: rtl/interp_fir_poly_pkg.sv
// Shared types and arithmetic helpers for the polyphase interpolating FIR.
// Values are carried at 64 bits so one helper serves any legal width configuration.
package interp_fir_poly_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    function automatic int acc_w(input int dw, input int cw, input int tpp);
        return dw + cw + $clog2(tpp);
    endfunction

    function automatic logic signed [63:0] round_const(input int frac);
        logic signed [63:0] r;
        r = '0;
        if (frac > 0) begin
            r[frac-1] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                     input int dw,
                                                     output logic sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (dw - 1));
        sat = 1'b0;
        r   = v;
        if (v > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (v < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/interp_phase_mac.sv
// Combinational multiply-accumulate, round-half-up and saturate for one phase.
module interp_phase_mac
    import interp_fir_poly_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int COEFF_WIDTH    = 16,
    parameter int COEFF_FRAC     = 14,
    parameter int TAPS_PER_PHASE = 4
) (
    input  logic signed [DATA_WIDTH-1:0]  x_i      [TAPS_PER_PHASE],
    input  logic signed [COEFF_WIDTH-1:0] c_i      [TAPS_PER_PHASE],
    output logic signed [DATA_WIDTH-1:0]  result_o,
    output logic                          sat_o
);

    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam int AW = acc_w(DATA_WIDTH, COEFF_WIDTH, TAPS_PER_PHASE);
    localparam int RW = AW + 1;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;
    logic signed [63:0]   sat_val;
    logic                 sat_hit;

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int k = 0; k < TAPS_PER_PHASE; k++) begin
            prod = PW'(x_i[k]) * PW'(c_i[k]);
            acc  = acc + AW'(prod);
        end
        // One guard bit above the accumulator so the rounding add cannot wrap.
        rounded  = RW'(acc) + RW'(round_const(COEFF_FRAC));
        shifted  = rounded >>> COEFF_FRAC;
        sat_val  = sat_trunc(64'(shifted), DATA_WIDTH, sat_hit);
        result_o = DATA_WIDTH'(sat_val);
        sat_o    = sat_hit;
    end

endmodule

// File: rtl/interp_fir_poly.sv
// Polyphase interpolating FIR: INTERP outputs per accepted input, valid/ready on both sides.
// Define INTERP_FIR_POLY_SAT_FLAG_EN to add the sticky sat_flag output and sat_clr input.
module interp_fir_poly
    import interp_fir_poly_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int COEFF_WIDTH    = 16,
    parameter int COEFF_FRAC     = 14,
    parameter int INTERP         = 4,
    parameter int TAPS_PER_PHASE = 4,
    localparam int NTAPS         = INTERP * TAPS_PER_PHASE,
    localparam int ADDR_W        = $clog2(NTAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    input  logic                          coeff_we,
    input  logic [ADDR_W-1:0]             coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_wdata
`ifdef INTERP_FIR_POLY_SAT_FLAG_EN
    ,
    output logic                          sat_flag,
    input  logic                          sat_clr
`endif
);

    localparam int PH_W = $clog2(INTERP);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(INTERP - 1);

    state_t                        state_q;
    logic [PH_W-1:0]               phase_q;
    logic signed [DATA_WIDTH-1:0]  x_q   [TAPS_PER_PHASE];
    logic signed [COEFF_WIDTH-1:0] c_q   [NTAPS];
    logic signed [DATA_WIDTH-1:0]  out_q;

    logic                          last_ph;
    logic                          accept;
    logic                          advance;
    logic                          load;
    logic [PH_W-1:0]               mac_ph;
    logic signed [DATA_WIDTH-1:0]  mac_x [TAPS_PER_PHASE];
    logic signed [COEFF_WIDTH-1:0] mac_c [TAPS_PER_PHASE];
    logic signed [DATA_WIDTH-1:0]  mac_res;
    logic                          mac_sat;

    assign last_ph   = (phase_q == LAST_PH);
    assign in_ready  = (state_q == IDLE) || (out_ready && last_ph);
    assign accept    = in_valid && in_ready;
    assign advance   = (state_q == RUN) && out_ready && !last_ph;
    assign load      = accept || advance;
    assign out_valid = (state_q == RUN);
    assign out_data  = out_q;

    // On accept the MAC sees the post-shift delay line, so the new sample lands in phase 0.
    always_comb begin
        mac_ph   = accept ? '0 : phase_q + 1'b1;
        mac_x[0] = accept ? in_data : x_q[0];
        for (int k = 1; k < TAPS_PER_PHASE; k++) begin
            mac_x[k] = accept ? x_q[k-1] : x_q[k];
        end
        for (int k = 0; k < TAPS_PER_PHASE; k++) begin
            mac_c[k] = c_q[ADDR_W'(int'(mac_ph) + k * INTERP)];
        end
    end

    interp_phase_mac #(
        .DATA_WIDTH     (DATA_WIDTH),
        .COEFF_WIDTH    (COEFF_WIDTH),
        .COEFF_FRAC     (COEFF_FRAC),
        .TAPS_PER_PHASE (TAPS_PER_PHASE)
    ) u_mac (
        .x_i      (mac_x),
        .c_i      (mac_c),
        .result_o (mac_res),
        .sat_o    (mac_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            out_q   <= '0;
            x_q     <= '{default: '0};
            c_q     <= '{default: '0};
        end else begin
            if (coeff_we && (int'(coeff_addr) < NTAPS)) begin
                c_q[coeff_addr] <= coeff_wdata;
            end
            if (accept) begin
                x_q     <= mac_x;
                out_q   <= mac_res;
                phase_q <= '0;
                state_q <= RUN;
            end else if (advance) begin
                out_q   <= mac_res;
                phase_q <= phase_q + 1'b1;
            end else if ((state_q == RUN) && out_ready && last_ph) begin
                state_q <= IDLE;
            end
        end
    end

`ifdef INTERP_FIR_POLY_SAT_FLAG_EN
    logic sat_flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else if (load && mac_sat) begin
            sat_flag_q <= 1'b1;
        end else if (sat_clr) begin
            sat_flag_q <= 1'b0;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    logic unused_sat;
    assign unused_sat = mac_sat & load;
`endif

endmodule

// File: tb/tb_interp_fir_poly.sv
// Directed bench for interp_fir_poly: table-driven streams plus backpressure, throughput and reset sequences.
module tb_interp_fir_poly;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               coeff_we;
    logic [3:0]         coeff_addr;
    logic signed [15:0] coeff_wdata;
`ifdef INTERP_FIR_POLY_SAT_FLAG_EN
    logic               sat_flag;
    logic               sat_clr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interp_fir_poly dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata)
`ifdef INTERP_FIR_POLY_SAT_FLAG_EN
        ,
        .sat_flag    (sat_flag),
        .sat_clr     (sat_clr)
`endif
    );

    typedef struct packed {
        logic [1:0]        cfg;
        logic [15:0]       din;
        logic [3:0][15:0]  exp;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [1:0] cfg, input int din,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.cfg    = cfg;
        v.din    = 16'(din);
        v.exp[0] = 16'(e0);
        v.exp[1] = 16'(e1);
        v.exp[2] = 16'(e2);
        v.exp[3] = 16'(e3);
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wr_coeff(input int addr, input int val);
        coeff_we    = 1'b1;
        coeff_addr  = 4'(addr);
        coeff_wdata = 16'(val);
        step();
        coeff_we    = 1'b0;
    endtask

    task automatic set_all(input int val);
        for (int n = 0; n < 16; n++) wr_coeff(n, val);
    endtask

    // Only the newest tap is non-zero, and phase p has gain (p+1)/4.
    task automatic set_ramp();
        set_all(0);
        for (int p = 0; p < 4; p++) wr_coeff(p, 4096 * (p + 1));
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    initial begin
        logic [1:0] cur;
        int seq [4];
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0;
`ifdef INTERP_FIR_POLY_SAT_FLAG_EN
        sat_clr = 1'b0;
`endif
        tbl[0]  = mk(1, 1000, 1000, 1000, 1000, 1000);
        tbl[1]  = mk(1, 0,    1000, 1000, 1000, 1000);
        tbl[2]  = mk(1, 0,    1000, 1000, 1000, 1000);
        tbl[3]  = mk(1, 0,    1000, 1000, 1000, 1000);
        tbl[4]  = mk(1, 0,    0, 0, 0, 0);
        tbl[5]  = mk(2, 3,    2, 0, 0, 0);
        tbl[6]  = mk(2, -3,   -1, 0, 0, 0);
        tbl[7]  = mk(3, 32767, 32767, 32767, 32767, 32767);
        tbl[8]  = mk(3, 32767, 32767, 32767, 32767, 32767);
        tbl[9]  = mk(3, 32767, 32767, 32767, 32767, 32767);
        tbl[10] = mk(3, 32767, 32767, 32767, 32767, 32767);
        tbl[11] = mk(3, -32768, 32767, 32767, 32767, 32767);
        tbl[12] = mk(3, -32768, -2, -2, -2, -2);
        tbl[13] = mk(3, -32768, -32768, -32768, -32768, -32768);
        tbl[14] = mk(3, -32768, -32768, -32768, -32768, -32768);

        step();
        do_reset();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_data", out_data, 0);

        cur = 2'd0;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].cfg != cur) begin
                do_reset();
                if (tbl[i].cfg == 2'd2) begin
                    set_all(0);
                    wr_coeff(0, 8192);
                end else begin
                    set_all(16384);
                end
                cur = tbl[i].cfg;
            end
            in_valid = 1'b1;
            in_data  = $signed(tbl[i].din);
            wait_ready("table");
            step();
            in_valid = 1'b0;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("table%0d_ph%0d_valid", i, p), 32'(out_valid), 1);
                chk($sformatf("table%0d_ph%0d_data", i, p), out_data, $signed(tbl[i].exp[p]));
                step();
            end
        end
        chk("table_end_idle", 32'(out_valid), 0);
`ifdef INTERP_FIR_POLY_SAT_FLAG_EN
        chk("sat_flag_set", 32'(sat_flag), 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_flag_clr", 32'(sat_flag), 0);
`endif

        // Backpressure at phase 2, with the next sample already offered.
        do_reset();
        set_ramp();
        in_valid = 1'b1;
        in_data  = 16'sd100;
        wait_ready("bp");
        step();
        in_valid = 1'b0;
        chk("bp_ph0", out_data, 25);
        step();
        chk("bp_ph1", out_data, 50);
        step();
        chk("bp_ph2", out_data, 75);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'sd200;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("bp_stall%0d_data", n), out_data, 75);
            chk($sformatf("bp_stall%0d_valid", n), 32'(out_valid), 1);
            chk($sformatf("bp_stall%0d_in_ready", n), 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_ph3", out_data, 100);
        chk("bp_ph3_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_ph0", out_data, 50);
        step();
        chk("bp_next_ph1", out_data, 100);
        step();
        chk("bp_next_ph2", out_data, 150);
        step();
        chk("bp_next_ph3", out_data, 200);
        step();
        chk("bp_end_idle", 32'(out_valid), 0);

        // Continuous streaming: no bubbles, in_ready only on the last phase.
        do_reset();
        set_ramp();
        seq = '{400, -800, 1200, 40};
        in_valid = 1'b1;
        in_data  = 16'(seq[0]);
        chk("tp_first_ready", 32'(in_ready), 1);
        step();
        for (int cyc = 0; cyc < 16; cyc++) begin
            chk($sformatf("tp%0d_valid", cyc), 32'(out_valid), 1);
            chk($sformatf("tp%0d_data", cyc), out_data, seq[cyc / 4] * (cyc % 4 + 1) / 4);
            chk($sformatf("tp%0d_in_ready", cyc), 32'(in_ready), ((cyc % 4) == 3) ? 1 : 0);
            if ((cyc % 4) == 3) begin
                if (cyc / 4 < 3) in_data = 16'(seq[cyc / 4 + 1]);
                else             in_valid = 1'b0;
            end
            step();
        end
        chk("tp_end_idle", 32'(out_valid), 0);

        // Reset while phase 1 is presented discards the rest and clears coefficients.
        do_reset();
        set_all(16384);
        in_valid = 1'b1;
        in_data  = 16'sd100;
        wait_ready("rstmid");
        step();
        in_valid = 1'b0;
        chk("rstmid_ph0", out_data, 100);
        step();
        chk("rstmid_ph1", out_data, 100);
        do_reset();
        chk("rstmid_out_valid", 32'(out_valid), 0);
        chk("rstmid_in_ready", 32'(in_ready), 1);
        chk("rstmid_out_data", out_data, 0);
        in_valid = 1'b1;
        in_data  = 16'sd500;
        step();
        in_valid = 1'b0;
        chk("rstmid_after_valid", 32'(out_valid), 1);
        chk("rstmid_after_data", out_data, 0);
        for (int n = 0; n < 4; n++) step();
        chk("rstmid_end_idle", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interp_fir_poly.md
Name: interp_fir_poly

Overview:
Parametrised polyphase interpolating FIR, the successor to the fixed 2-tap interp_filt. For each accepted input sample it produces INTERP output samples, one per phase, each a rounded and saturated MAC over TAPS_PER_PHASE delayed inputs.
- Valid/ready handshakes on both sides.
- Run-time coefficient write port.
- Sits between the sample source and the DAC/upsampled datapath.

Parameters:
DATA_WIDTH, 16, width of input/output samples (signed two's complement)
COEFF_WIDTH, 16, width of each coefficient (signed)
COEFF_FRAC, 14, fractional bits of coefficients (16384 = 1.0)
INTERP, 4, interpolation factor L (number of phases), >=2
TAPS_PER_PHASE, 4, delay-line depth; total taps NTAPS = INTERP*TAPS_PER_PHASE

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input this cycle
in_data  in  DATA_WIDTH  input sample (signed)
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts output
out_data  out  DATA_WIDTH  interpolated sample (signed)
coeff_we  in  1  coefficient write strobe
coeff_addr  in  $clog2(NTAPS)  tap index n, 0..NTAPS-1
coeff_wdata  in  COEFF_WIDTH  coefficient value

Behaviour:
- Reset (one cycle of rst sampled high):
  - state=IDLE, phase=0.
  - out_valid=0, out_data=0, in_ready=1 in the cycle after reset.
  - Delay line x[0..TPP-1]=0; all coefficients c[0..NTAPS-1]=0.
- States: IDLE, RUN.
  - IDLE: in_ready=1, out_valid=0.
  - RUN: out_valid=1, out_data holds the current phase result.
- Accept = in_valid && in_ready. On accept:
  - x shifts (x[k]<=x[k-1]); x[0]<=in_data.
  - Output register loads the phase 0 result; phase<=0; state<=RUN.
  - Latency: accept in cycle t gives out_valid=1 with phase 0 in cycle t+1.
- In RUN, out_valid && out_ready with phase<INTERP-1: phase<=phase+1 and the output register loads the next phase result.
- In RUN, out_valid && out_ready with phase==INTERP-1:
  - in_ready=1 this cycle (combinational from out_ready).
  - If in_valid: accept as above; out_valid stays 1 (no bubble). Otherwise state<=IDLE.
- Otherwise in_ready=0 in RUN.
- When out_ready=0: out_data and phase hold stable; no input is accepted.
- Phase result p:
  - y = sum over k=0..TPP-1 of x[k]*c[p+k*INTERP], with x[0] the newest sample.
  - Computed on the post-shift delay line when loading on an accept.
- Arithmetic:
  - Each product is DATA_WIDTH+COEFF_WIDTH bits.
  - Accumulator is DATA_WIDTH+COEFF_WIDTH+$clog2(TPP) bits; no internal overflow.
  - Round half up: add 2^(COEFF_FRAC-1), then arithmetic shift right by COEFF_FRAC.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
- Coefficient write: c[coeff_addr]<=coeff_wdata when coeff_we=1.
  - Allowed in any state; the new value is visible from the next cycle.
  - A phase loads using the coefficients held in the cycle the output register loads.
  - Out-of-range addr (NTAPS not a power of 2) is ignored.
- Reset mid-operation: the pending phases are discarded; an output handshake in the same cycle as rst is void.

Optional Feature:
INTERP_FIR_POLY_SAT_FLAG_EN
- With the macro: extra ports sat_flag (out, 1) and sat_clr (in, 1).
  - sat_flag is sticky; it sets in the cycle after any output register load that saturated.
  - sat_clr clears it; set has priority over clear in the same cycle.
  - rst clears it.
- Without the macro: neither port exists and no flag logic is built.

Decomposition:
- interp_fir_poly_pkg:
  - ACC_W localparam function, ROUND_CONST.
  - sat_trunc function (accumulator to DATA_WIDTH).
  - state_t enum {IDLE, RUN}.
- Sub-module interp_phase_mac: combinational MAC, round and saturate for one phase.
  - Inputs: TPP samples, TPP coefficients.
  - Outputs: result, sat.
  - The top instantiates one copy and muxes coefficients by phase.

Test Plan:
(Defaults: DW=16, CW=16, FRAC=14, L=4, TPP=4.)
1. Unity impulse: all c=16384; input 1000 then zeros, out_ready=1.
   -> out_data=1000 for 16 consecutive outputs (4 inputs x 4 phases), then 0.
2. Rounding: c[0]=8192, others 0; inputs 3 and -3.
   -> phase 0 outputs 2 and -1; phases 1-3 output 0.
3. Saturation: all c=16384; four inputs of 32767, then four inputs of -32768.
   -> output clamps to 32767, then to -32768. With the macro, sat_flag=1 until sat_clr.
4. Backpressure: out_ready=0 for 5 cycles at phase 2.
   -> out_data and phase stable, in_ready=0; after release phases 2 and 3 appear; no sample lost or duplicated.
5. Full throughput: in_valid=1 and out_ready=1 continuously.
   -> in_ready pulses once every 4 cycles; out_valid stays 1 from the cycle after the first accept.
6. Reset mid-run: rst during phase 1.
   -> next cycle out_valid=0, in_ready=1; the next input with c unwritten gives out_data=0.
